// File: rtl/miriscv_lsu.sv
// Load-store unit: turns core byte/half/word accesses into aligned word
// transactions on the req/gnt/rvalid data bus, with a grant/response timeout.
module miriscv_lsu #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_stall_o,
  output logic        lsu_misalign_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_e;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         off_q, off_d;
  logic [2:0]         size_q, size_d;
  logic               we_q, we_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               illegal;
  logic               legal;
  logic               timeout_hit;
  logic               req_c;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [31:0]        ld_ext;

  always_comb begin
    illegal = 1'b0;
    case (lsu_size_i)
      3'd0:    illegal = 1'b0;
      3'd1:    illegal = lsu_addr_i[0];
      3'd2:    illegal = |lsu_addr_i[1:0];
      3'd4:    illegal = lsu_we_i;
      3'd5:    illegal = lsu_we_i | lsu_addr_i[0];
      default: illegal = 1'b1;
    endcase
  end

  assign legal          = ~illegal;
  assign lsu_misalign_o = lsu_req_i & illegal;
  assign lsu_stall_o    = lsu_req_i & legal & (state_q != S_DONE);
  assign timeout_hit    = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  // Bus side attributes come straight from the core inputs, which the core
  // holds stable for the whole stalled transaction.
  assign data_we_o   = lsu_we_i;
  assign data_addr_o = {lsu_addr_i[31:2], 2'b00};

  always_comb begin
    data_be_o    = '0;
    data_wdata_o = lsu_wdata_i;
    case (lsu_size_i[1:0])
      2'd0: begin
        data_be_o    = 4'b0001 << lsu_addr_i[1:0];
        data_wdata_o = {4{lsu_wdata_i[7:0]}};
      end
      2'd1: begin
        data_be_o    = 4'b0011 << {lsu_addr_i[1], 1'b0};
        data_wdata_o = {2{lsu_wdata_i[15:0]}};
      end
      2'd2:    data_be_o = '1;
      default: data_be_o = '0;
    endcase
  end

  assign ld_byte = data_rdata_i[{off_q, 3'b000} +: 8];
  assign ld_half = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];

  always_comb begin
    ld_ext = data_rdata_i;
    case (size_q)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_ext = {24'd0, ld_byte};
      3'd5:    ld_ext = {16'd0, ld_half};
      default: ld_ext = data_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    size_d  = size_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    req_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (lsu_req_i && legal) begin
          req_c   = 1'b1;
          off_d   = lsu_addr_i[1:0];
          size_d  = lsu_size_i;
          we_d    = lsu_we_i;
          state_d = data_gnt_i ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        // Timeout wins over a coincident grant: the request is withdrawn.
        if (timeout_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          req_c = 1'b1;
          if (data_gnt_i) begin
            off_d   = lsu_addr_i[1:0];
            size_d  = lsu_size_i;
            we_d    = lsu_we_i;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (data_rvalid_i) begin
          state_d = S_DONE;
          if (!we_q) rdata_d = ld_ext;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data_req_o  = req_c & ~rst_i;
  assign lsu_rdata_o = rdata_q;
  assign lsu_err_o   = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      size_q  <= size_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed bench for miriscv_lsu: drives the core side and plays the data bus
// by hand, comparing against hand-computed expected values.
module tb_miriscv_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic [31:0] lsu_rdata_o;
  logic        lsu_stall_o;
  logic        lsu_misalign_o;
  logic        lsu_err_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk_i = ~clk_i;

  miriscv_lsu #(.TIMEOUT(8), .CNT_W(16)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .lsu_req_i      (lsu_req_i),
    .lsu_we_i       (lsu_we_i),
    .lsu_size_i     (lsu_size_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_rdata_o    (lsu_rdata_o),
    .lsu_stall_o    (lsu_stall_o),
    .lsu_misalign_o (lsu_misalign_o),
    .lsu_err_o      (lsu_err_o),
    .data_req_o     (data_req_o),
    .data_we_o      (data_we_o),
    .data_be_o      (data_be_o),
    .data_addr_o    (data_addr_o),
    .data_wdata_o   (data_wdata_o),
    .data_gnt_i     (data_gnt_i),
    .data_rvalid_i  (data_rvalid_i),
    .data_rdata_i   (data_rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One core access. Grant is given gnt_dly cycles after the request starts
  // (never if no_gnt), rvalid one cycle after the grant. Returns once the
  // stall drops, sampling the DONE-cycle results, then idles the core.
  task automatic run_txn(
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  int          gnt_dly,
    input  logic        no_gnt,
    input  logic [31:0] word,
    output int          stall_cyc,
    output int          req_cyc,
    output logic [3:0]  be_seen,
    output logic [31:0] addr_seen,
    output logic [31:0] wdata_seen,
    output logic [31:0] rdata_done,
    output logic        err_done
  );
    bit finished = 1'b0;
    stall_cyc  = 0;
    req_cyc    = 0;
    be_seen    = '0;
    addr_seen  = '0;
    wdata_seen = '0;
    rdata_done = '0;
    err_done   = 1'b0;
    lsu_req_i   = 1'b1;
    lsu_we_i    = we;
    lsu_size_i  = size;
    lsu_addr_i  = addr;
    lsu_wdata_i = wdata;
    for (int c = 0; c < 40; c++) begin
      data_gnt_i    = !no_gnt && (c == gnt_dly);
      data_rvalid_i = !no_gnt && (c == gnt_dly + 1);
      data_rdata_i  = data_rvalid_i ? word : 32'hDEAD_BEEF;
      #1;
      if (!lsu_stall_o) begin
        rdata_done = lsu_rdata_o;
        err_done   = lsu_err_o;
        finished   = 1'b1;
        break;
      end
      stall_cyc++;
      if (data_req_o) begin
        req_cyc++;
        be_seen    = data_be_o;
        addr_seen  = data_addr_o;
        wdata_seen = data_wdata_o;
      end
      @(posedge clk_i);
      #1;
    end
    check("txn_completes", {31'd0, finished}, 32'd1);
    lsu_req_i     = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    step();
  endtask

  int          st, rq;
  logic [3:0]  be;
  logic [31:0] ad, wd, rd;
  logic        er;

  initial begin
    rst_i         = 1'b1;
    lsu_req_i     = 1'b0;
    lsu_we_i      = 1'b0;
    lsu_size_i    = 3'd0;
    lsu_addr_i    = '0;
    lsu_wdata_i   = '0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'hFFFF_FFFF;
    step();
    step();
    check("rst_req",   {31'd0, data_req_o},  32'd0);
    check("rst_rdata", lsu_rdata_o,          32'd0);
    check("rst_err",   {31'd0, lsu_err_o},   32'd0);
    check("rst_stall", {31'd0, lsu_stall_o}, 32'd0);
    rst_i = 1'b0;
    step();
    data_rvalid_i = 1'b0;
    check("stale_rvalid", lsu_rdata_o, 32'd0);

    // LB 0x13 from 0x80FF7F01
    run_txn(1'b0, 3'd0, 32'h13, '0, 0, 1'b0, 32'h80FF7F01, st, rq, be, ad, wd, rd, er);
    check("lb_be",    {28'd0, be}, 32'h8);
    check("lb_addr",  ad,          32'h10);
    check("lb_rdata", rd,          32'hFFFFFF80);
    check("lb_stall", st,          32'd2);
    check("lb_err",   {31'd0, er}, 32'd0);

    run_txn(1'b0, 3'd5, 32'h12, '0, 0, 1'b0, 32'h80FF7F01, st, rq, be, ad, wd, rd, er);
    check("lhu_be",    {28'd0, be}, 32'hC);
    check("lhu_rdata", rd,          32'h000080FF);

    run_txn(1'b0, 3'd1, 32'h12, '0, 0, 1'b0, 32'h80FF7F01, st, rq, be, ad, wd, rd, er);
    check("lh_rdata", rd, 32'hFFFF80FF);

    run_txn(1'b0, 3'd4, 32'h11, '0, 0, 1'b0, 32'h80FF7F01, st, rq, be, ad, wd, rd, er);
    check("lbu_be",    {28'd0, be}, 32'h2);
    check("lbu_rdata", rd,          32'h0000007F);

    // SB 0xAB to 0x21 with grant delayed by 3 cycles
    run_txn(1'b1, 3'd0, 32'h21, 32'h000000AB, 3, 1'b0, 32'h0, st, rq, be, ad, wd, rd, er);
    check("sb_req_cyc", rq,          32'd4);
    check("sb_be",      {28'd0, be}, 32'h2);
    check("sb_wdata",   wd,          32'hABABABAB);
    check("sb_addr",    ad,          32'h20);
    check("sb_err",     {31'd0, er}, 32'd0);
    check("sb_rdata_kept", rd,       32'h0000007F);

    run_txn(1'b1, 3'd1, 32'h22, 32'h1234BEEF, 0, 1'b0, 32'h0, st, rq, be, ad, wd, rd, er);
    check("sh_be",    {28'd0, be}, 32'hC);
    check("sh_wdata", wd,          32'hBEEFBEEF);

    // Misaligned LW and store with an unsigned size
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h06;
    #1;
    check("lw_mis_flag",  {31'd0, lsu_misalign_o}, 32'd1);
    check("lw_mis_req",   {31'd0, data_req_o},     32'd0);
    check("lw_mis_stall", {31'd0, lsu_stall_o},    32'd0);
    step();
    lsu_we_i = 1'b1; lsu_size_i = 3'd5; lsu_addr_i = 32'h08;
    #1;
    check("shu_mis_flag",  {31'd0, lsu_misalign_o}, 32'd1);
    check("shu_mis_req",   {31'd0, data_req_o},     32'd0);
    check("shu_mis_stall", {31'd0, lsu_stall_o},    32'd0);
    lsu_req_i = 1'b0;
    #1;
    check("mis_flag_idle", {31'd0, lsu_misalign_o}, 32'd0);
    step();

    // Unmapped address, no grant: timeout after 8 request cycles
    run_txn(1'b0, 3'd2, 32'h100, '0, 0, 1'b1, 32'h0, st, rq, be, ad, wd, rd, er);
    check("to_req_cyc", rq,          32'd8);
    check("to_err",     {31'd0, er}, 32'd1);
    check("to_rdata",   rd,          32'd0);
    check("to_err_pulse", {31'd0, lsu_err_o}, 32'd0);

    // Reset while in RESP, then a late rvalid must be ignored
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h04;
    data_gnt_i = 1'b1;
    step();
    data_gnt_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check("rst_mid_req", {31'd0, data_req_o}, 32'd0);
    step();
    rst_i = 1'b0; lsu_req_i = 1'b0;
    data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFE_F00D;
    #1;
    check("rst_resp_req",   {31'd0, data_req_o},  32'd0);
    check("rst_resp_stall", {31'd0, lsu_stall_o}, 32'd0);
    check("rst_resp_rdata", lsu_rdata_o,          32'd0);
    step();
    data_rvalid_i = 1'b0;
    check("late_rvalid_rdata", lsu_rdata_o,        32'd0);
    check("late_rvalid_err",   {31'd0, lsu_err_o}, 32'd0);

    run_txn(1'b0, 3'd2, 32'h04, '0, 0, 1'b0, 32'h12345678, st, rq, be, ad, wd, rd, er);
    check("lw_be",    {28'd0, be}, 32'hF);
    check("lw_addr",  ad,          32'h04);
    check("lw_rdata", rd,          32'h12345678);
    check("lw_stall", st,          32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
